// File: rtl/rvfpm_result_fifo.sv
// Result-side buffer between the FPU result port and the core's XIF result interface.
// In-order FIFO with first-word-fall-through head and a per-register pending mask.
module rvfpm_result_fifo #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    parameter int NUM_F_REGS = 32
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [X_ID_WIDTH-1:0]      in_id,
    input  logic [FLEN-1:0]            in_data,
    input  logic [4:0]                 in_rd,
    input  logic                       in_we,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [X_ID_WIDTH-1:0]      result_id,
    output logic [FLEN-1:0]            result_data,
    output logic [4:0]                 result_rd,
    output logic                       result_we,
    output logic [$clog2(DEPTH):0]     count,
    output logic [NUM_F_REGS-1:0]      pending_rd,
    output logic                       overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [X_ID_WIDTH-1:0] mem_id   [DEPTH];
    logic [FLEN-1:0]       mem_data [DEPTH];
    logic [4:0]            mem_rd   [DEPTH];
    logic                  mem_we   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // The extra pointer MSB distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign in_ready     = !full;
    assign result_valid = !empty;
    assign push         = in_valid && in_ready;
    assign pop          = result_valid && result_ready;

    assign result_id   = result_valid ? mem_id[rd_ptr[AW-1:0]]   : '0;
    assign result_data = result_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
    assign result_rd   = result_valid ? mem_rd[rd_ptr[AW-1:0]]   : '0;
    assign result_we   = result_valid ? mem_we[rd_ptr[AW-1:0]]   : 1'b0;

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (in_valid && full) begin
                overflow_err <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; occupancy is defined purely by the pointers.
    always_ff @(posedge ck) begin
        if (!rst && !flush && push) begin
            mem_id[wr_ptr[AW-1:0]]   <= in_id;
            mem_data[wr_ptr[AW-1:0]] <= in_data;
            mem_rd[wr_ptr[AW-1:0]]   <= in_rd;
            mem_we[wr_ptr[AW-1:0]]   <= in_we;
        end
    end

    always_comb begin
        logic [AW-1:0] offset;
        pending_rd = '0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rd_ptr[AW-1:0];
            if ((PW'(offset) < count) && mem_we[i] && (int'(mem_rd[i]) < NUM_F_REGS)) begin
                pending_rd[mem_rd[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfpm_result_fifo.sv
// Self-checking bench for rvfpm_result_fifo: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_rvfpm_result_fifo;

    localparam int DEPTH = 4;
    localparam int XW    = 4;
    localparam int FLEN  = 32;
    localparam int NR    = 32;

    logic            ck;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XW-1:0]   in_id;
    logic [FLEN-1:0] in_data;
    logic [4:0]      in_rd;
    logic            in_we;
    logic            result_valid;
    logic            result_ready;
    logic [XW-1:0]   result_id;
    logic [FLEN-1:0] result_data;
    logic [4:0]      result_rd;
    logic            result_we;
    logic [2:0]      count;
    logic [NR-1:0]   pending_rd;
    logic            overflow_err;

    typedef struct packed {
        logic [XW-1:0]   id;
        logic [FLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    entry_t modelQ[$];
    logic   modelOvf;
    int     passCount;
    int     checkCount;

    rvfpm_result_fifo #(
        .DEPTH(DEPTH), .X_ID_WIDTH(XW), .FLEN(FLEN), .NUM_F_REGS(NR)
    ) dut (
        .ck(ck), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_data(in_data), .in_rd(in_rd), .in_we(in_we),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_id(result_id), .result_data(result_data),
        .result_rd(result_rd), .result_we(result_we),
        .count(count), .pending_rd(pending_rd), .overflow_err(overflow_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            passCount++;
        end
    endtask

    // Compares every DUT output against the reference queue.
    task automatic checkModel();
        logic [NR-1:0] expPending;
        entry_t        head;
        expPending = '0;
        foreach (modelQ[k]) begin
            if (modelQ[k].we) expPending[modelQ[k].rd] = 1'b1;
        end
        head = (modelQ.size() != 0) ? modelQ[0] : '0;
        checkOutput("result_valid", 64'(result_valid), 64'(modelQ.size() != 0));
        checkOutput("in_ready",     64'(in_ready),     64'(modelQ.size() < DEPTH));
        checkOutput("count",        64'(count),        64'(modelQ.size()));
        checkOutput("pending_rd",   64'(pending_rd),   64'(expPending));
        checkOutput("overflow_err", 64'(overflow_err), 64'(modelOvf));
        checkOutput("result_id",    64'(result_id),    64'(head.id));
        checkOutput("result_data",  64'(result_data),  64'(head.data));
        checkOutput("result_rd",    64'(result_rd),    64'(head.rd));
        checkOutput("result_we",    64'(result_we),    64'(head.we));
    endtask

    // Drives one cycle of inputs, advances the model at the edge, then checks.
    task automatic applyStimulus(input logic v, input logic [XW-1:0] id, input logic [FLEN-1:0] d,
                                 input logic [4:0] rd, input logic we, input logic rdy,
                                 input logic fl, input logic rs);
        bit     isFull;
        bit     doPop;
        entry_t e;
        in_valid     = v;
        in_id        = id;
        in_data      = d;
        in_rd        = rd;
        in_we        = we;
        result_ready = rdy;
        flush        = fl;
        rst          = rs;
        isFull = (modelQ.size() == DEPTH);
        doPop  = (modelQ.size() != 0) && rdy;
        e.id = id; e.data = d; e.rd = rd; e.we = we;
        @(posedge ck);
        if (rs) begin
            modelQ.delete();
            modelOvf = 1'b0;
        end else begin
            if (v && isFull) modelOvf = 1'b1;
            if (fl) begin
                modelQ.delete();
            end else begin
                if (doPop) void'(modelQ.pop_front());
                if (v && !isFull) modelQ.push_back(e);
            end
        end
        #1;
        checkModel();
    endtask

    task automatic idleCycle(input logic rdy);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pushOne(input logic [XW-1:0] id, input logic [4:0] rd, input logic we, input logic rdy);
        applyStimulus(1'b1, id, {28'h3F80000, id}, rd, we, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        modelOvf   = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_id = '0; in_data = '0;
        in_rd = '0; in_we = 1'b0; result_ready = 1'b0;

        // Reset state
        doReset();
        doReset();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_count",    64'(count),    64'd0);

        // First push appears on the next cycle
        applyStimulus(1'b1, 4'd1, 32'h3F800000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("first_data",    64'(result_data), 64'h3F800000);
        checkOutput("first_pending", 64'(pending_rd),  64'h20);

        // Fill to full, overflow, then drain in order
        doReset();
        for (int i = 1; i <= 4; i++) pushOne(XW'(i), 5'(i), 1'b1, 1'b0);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("full_count",    64'(count),    64'd4);
        pushOne(4'd5, 5'd9, 1'b1, 1'b0);
        checkOutput("ovf_set",   64'(overflow_err), 64'd1);
        checkOutput("ovf_count", 64'(count),        64'd4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_id", 64'(result_id), 64'(i));
            idleCycle(1'b1);
        end

        // Head stable under back-pressure
        doReset();
        pushOne(4'd7, 5'd3, 1'b1, 1'b0);
        pushOne(4'd8, 5'd4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b0);
            checkOutput("hold_id", 64'(result_id), 64'd7);
        end
        idleCycle(1'b1);
        checkOutput("pop1_count", 64'(count), 64'd1);
        idleCycle(1'b1);
        checkOutput("pop2_count", 64'(count), 64'd0);

        // Steady push+pop, pointers wrap
        doReset();
        pushOne(4'd0, 5'd1, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            pushOne(XW'(i % 16), 5'(i), 1'b1, 1'b1);
            checkOutput("steady_count", 64'(count), 64'd1);
        end

        // Pending mask with duplicate rd and a we=0 entry
        doReset();
        pushOne(4'd1, 5'd2, 1'b1, 1'b0);
        pushOne(4'd2, 5'd2, 1'b1, 1'b0);
        pushOne(4'd3, 5'd7, 1'b1, 1'b0);
        idleCycle(1'b1);
        checkOutput("pend_84", 64'(pending_rd), 64'h84);
        idleCycle(1'b1);
        checkOutput("pend_80", 64'(pending_rd), 64'h80);
        pushOne(4'd4, 5'd9, 1'b0, 1'b1);
        checkOutput("pend_no9", 64'(pending_rd[9]), 64'd0);

        // Flush keeps overflow_err; rst clears it
        doReset();
        for (int i = 1; i <= 5; i++) pushOne(XW'(i), 5'(i), 1'b1, 1'b0);
        idleCycle(1'b1);
        checkOutput("pre_flush_count", 64'(count), 64'd3);
        applyStimulus(1'b1, 4'd9, 32'h1234, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_count", 64'(count),        64'd0);
        checkOutput("flush_valid", 64'(result_valid), 64'd0);
        checkOutput("flush_ovf",   64'(overflow_err), 64'd1);
        pushOne(4'd2, 5'd3, 1'b1, 1'b0);
        doReset();
        checkOutput("rst_ovf",   64'(overflow_err), 64'd0);
        checkOutput("rst_valid", 64'(result_valid), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic fl;
            logic v;
            fl = ($urandom_range(39) == 0);
            v  = !fl && ($urandom_range(3) != 0);
            applyStimulus(v, XW'($urandom), $urandom, 5'($urandom), 1'($urandom),
                          ($urandom_range(2) != 0), fl, ($urandom_range(99) == 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
